// File: rtl/bin_to_sevenseg.sv
// Sequential binary to N-digit seven-segment encoder (shift-add-3, one bit per clock).
// Optional macro BIN_TO_SEVENSEG_BLANK_LZ_EN blanks leading zero digits above the ones digit.
module bin_to_sevenseg #(
    parameter int N = 2,
    parameter int W = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [W-1:0]        bin,
    output logic                ready,
    output logic                done,
    output logic                overflow,
    output logic [N-1:0][6:0]   digit_values
);

    localparam int SW = 4*N + W;
    localparam int CW = $clog2(W + 1);
    localparam longint unsigned MAXV = 64'(10**N) - 64'd1;
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       sr, sr_adj;
    logic [CW-1:0]       cnt;
    logic                ovf;
    logic [N-1:0][6:0]   enc;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = ENCODE;
            ENCODE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    // Add-3 correction on each kept BCD nibble before the shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < N; i++) begin
            if (sr[W + 4*i +: 4] >= 4'd5)
                sr_adj[W + 4*i +: 4] = sr[W + 4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        logic hi_zero;
        logic [3:0] d;
        enc = '0;
        hi_zero = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            d = sr[W + 4*i +: 4];
`ifdef BIN_TO_SEVENSEG_BLANK_LZ_EN
            if (i >= 1 && hi_zero && d == 4'd0) enc[i] = BLANK;
            else                                enc[i] = seg7(d);
`else
            enc[i] = seg7(d);
`endif
            hi_zero = hi_zero & (d == 4'd0);
            if (ovf) enc[i] = DASH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            cnt          <= '0;
            ovf          <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
            digit_values <= {N{BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (load) begin
                    sr  <= SW'(bin);
                    cnt <= CW'(W);
                    ovf <= (64'(bin) > MAXV);
                end
                SHIFT: begin
                    sr  <= {sr_adj[SW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                end
                ENCODE: begin
                    digit_values <= enc;
                    overflow     <= ovf;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_sevenseg.sv
// Directed, table-driven bench for bin_to_sevenseg (N=2, W=7), plus multi-cycle corner sequences.
module tb_bin_to_sevenseg;
    localparam int N = 2;
    localparam int W = 7;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           S9 = 7'b0010000, BLK = 7'b1111111, DSH = 7'b0111111;
`ifdef BIN_TO_SEVENSEG_BLANK_LZ_EN
    localparam logic [6:0] LZ = BLK;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic clk = 1'b0;
    logic reset, load, ready, done, overflow;
    logic [W-1:0] bin;
    logic [N-1:0][6:0] digit_values;

    int n_chk = 0;
    int n_fail = 0;
    logic [13:0] prev_dv;
    logic prev_ovf;

    typedef struct {
        logic [W-1:0] b;
        logic [6:0]   d0;
        logic [6:0]   d1;
        logic         ovf;
    } vec_t;
    vec_t vt[9];

    bin_to_sevenseg #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .load(load), .bin(bin),
        .ready(ready), .done(done), .overflow(overflow), .digit_values(digit_values)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called #1 after a clock edge; checks latency, ready, hold and final result.
    task automatic run_conv(input logic [W-1:0] b, input logic [6:0] d0,
                            input logic [6:0] d1, input logic ov);
        bin  = b;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        chk("ready_after_accept", 32'(ready), 32'd0);
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge clk); #1;
            if (c < W + 1) begin
                chk("busy_ready", 32'(ready), 32'd0);
                chk("busy_done", 32'(done), 32'd0);
            end
            if (c == 4) begin
                chk("hold_digits", 32'(digit_values), 32'(prev_dv));
                chk("hold_ovf", 32'(overflow), 32'(prev_ovf));
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("ready_back", 32'(ready), 32'd1);
        chk("digit0", 32'(digit_values[0]), 32'(d0));
        chk("digit1", 32'(digit_values[1]), 32'(d1));
        chk("overflow", 32'(overflow), 32'(ov));
        @(posedge clk); #1;
        chk("done_single", 32'(done), 32'd0);
        prev_dv  = {d1, d0};
        prev_ovf = ov;
    endtask

    initial begin
        int dones;
        vt[0] = '{7'd42,  S2,  S4,  1'b0};
        vt[1] = '{7'd100, DSH, DSH, 1'b1};
        vt[2] = '{7'd127, DSH, DSH, 1'b1};
        vt[3] = '{7'd99,  S9,  S9,  1'b0};
        vt[4] = '{7'd5,   S5,  LZ,  1'b0};
        vt[5] = '{7'd0,   S0,  LZ,  1'b0};
        vt[6] = '{7'd10,  S0,  S1,  1'b0};
        vt[7] = '{7'd67,  S7,  S6,  1'b0};
        vt[8] = '{7'd38,  S8,  S3,  1'b0};

        reset = 1'b1; load = 1'b0; bin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_digits", 32'(digit_values), 32'h3fff);
        reset = 1'b0;
        prev_dv = 14'h3fff; prev_ovf = 1'b0;

        for (int i = 0; i < 9; i++) run_conv(vt[i].b, vt[i].d0, vt[i].d1, vt[i].ovf);

        // load during conversion is ignored
        bin = 7'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; dones = 0;
        for (int c = 1; c <= W + 4; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (c == 2) begin load = 1'b1; bin = 7'd7; end
            if (c == 3) load = 1'b0;
        end
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_digits", 32'(digit_values), 32'({S4, S2}));
        prev_dv = {S4, S2}; prev_ovf = 1'b0;

        // reset mid-conversion aborts
        bin = 7'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        chk("abort_digits", 32'(digit_values), 32'h3fff);
        dones = 0;
        for (int c = 0; c < W + 3; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_nodone", 32'(dones), 32'd0);
        prev_dv = 14'h3fff; prev_ovf = 1'b0;
        run_conv(7'd9, S9, LZ, 1'b0);

        // load held high re-triggers on the first IDLE cycle
        bin = 7'd38; load = 1'b1;
        @(posedge clk); #1;
        repeat (W + 1) @(posedge clk);
        #1;
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_ready", 32'(ready), 32'd1);
        bin = 7'd67;
        @(posedge clk); #1;
        load = 1'b0;
        chk("b2b_retrig", 32'(ready), 32'd0);
        repeat (W + 1) @(posedge clk);
        #1;
        chk("b2b_done2", 32'(done), 32'd1);
        chk("b2b_digits", 32'(digit_values), 32'({S6, S7}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
